// File: rtl/mips_pkg.sv
// Constants and types shared by the EX-stage blocks: ALU op codes, the
// multiply/divide op select and the sequencer state encoding.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_STEP = 3'd1,
    ST_DIV_CMP  = 3'd2,
    ST_DIV_SUB  = 3'd3,
    ST_DONE     = 3'd4
  } mdu_state_t;

endpackage

// File: rtl/mips_alu.sv
// Shared EX-stage ALU: 16-bit add, subtract and unsigned set-less-than.
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_cnt,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_cnt)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative unsigned 16x16 MULTU/DIVU sequencer that borrows the shared ALU
// while busy, building the result into hi/lo one bit per step.
module mul_div_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_cnt,
  input  logic [WIDTH-1:0] alu_result
);

  mdu_state_t       r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [3:0]       r_cnt;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_rshift;
  logic             w_msb;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == 4'd15);

  // Division: partial remainder shifted left with the next dividend bit.
  assign w_rshift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_msb    = r_hi[WIDTH-1];

  // Multiply: the ALU only returns 16 bits, so the carry is recovered by wrap detection.
  assign w_sum   = r_lo[0] ? alu_result : r_hi;
  assign w_carry = r_lo[0] && (alu_result < r_hi);

  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_cnt = ALU_ADD;
    case (r_state)
      ST_MUL_STEP: begin
        alu_in1 = r_hi;
        alu_in2 = r_opb;
        alu_cnt = ALU_ADD;
      end
      ST_DIV_CMP: begin
        alu_in1 = w_rshift;
        alu_in2 = r_opb;
        alu_cnt = ALU_SLT;
      end
      ST_DIV_SUB: begin
        alu_in1 = r_hi;
        alu_in2 = r_opb;
        alu_cnt = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_dbz <= 1'b0;
      if (op == OP_MULTU) begin
        r_hi    <= '0;
        r_lo    <= b;
        r_opb   <= a;
        r_state <= ST_MUL_STEP;
      end else if (b == '0) begin
        r_hi    <= a;
        r_lo    <= '1;
        r_dbz   <= 1'b1;
        r_state <= ST_DONE;
      end else begin
        r_hi    <= '0;
        r_lo    <= a;
        r_opb   <= b;
        r_state <= ST_DIV_CMP;
      end
    end else begin
      case (r_state)
        ST_MUL_STEP: begin
          {r_hi, r_lo} <= {w_carry, w_sum, r_lo[WIDTH-1:1]};
          r_cnt        <= r_cnt + 4'd1;
          if (w_last) r_state <= ST_DONE;
        end
        ST_DIV_CMP: begin
          r_hi <= w_rshift;
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          // A set 17th bit means r' certainly exceeds the divisor.
          if (w_msb || !alu_result[0]) begin
            r_state <= ST_DIV_SUB;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DIV_SUB: begin
          r_hi    <= alu_result;
          r_lo[0] <= 1'b1;
          r_cnt   <= r_cnt + 4'd1;
          r_state <= w_last ? ST_DONE : ST_DIV_CMP;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_MUL_STEP) || (r_state == ST_DIV_CMP) ||
                       (r_state == ST_DIV_SUB);
  assign done        = (r_state == ST_DONE);
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq closed through the real ALU, checked against plain
// arithmetic (a*b, a/b, a%b) and the cycle-count rules.
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, op;
  logic [15:0] a, b;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo, alu_in1, alu_in2, alu_result;
  logic [2:0]  alu_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] last_hi, last_lo;
  logic        last_dbz;

  always #5 clk = ~clk;

  mul_div_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cnt(alu_cnt), .alu_result(alu_result)
  );

  mips_alu #(.WIDTH(16)) u_alu (
    .i_a(alu_in1), .i_b(alu_in2), .i_cnt(alu_cnt), .o_result(alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic o, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] eh, output logic [15:0] el,
                           output logic ed, output int ec);
    logic [31:0] p;
    if (o == 1'b0) begin
      p  = {16'b0, x} * {16'b0, y};
      eh = p[31:16];
      el = p[15:0];
      ed = 1'b0;
      ec = 17;
    end else if (y == 16'd0) begin
      eh = x;
      el = 16'hFFFF;
      ed = 1'b1;
      ec = 1;
    end else begin
      el = x / y;
      eh = x % y;
      ed = 1'b0;
      ec = 17 + $countones(el);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_hilo"}, {hi, lo}, 0);
    chk({tag, "_alu"}, {alu_in1, alu_in2, alu_cnt}, 0);
  endtask

  // Starts an op; returns at #1 in the done cycle (or after an injected reset).
  task automatic run_op(input string tag, input logic o, input logic [15:0] x,
                        input logic [15:0] y, input int inj, input int rst_at);
    logic [15:0] eh, el;
    logic        ed;
    int          ec, n;
    bit          seen;
    ref_model(o, x, y, eh, el, ed, ec);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    seen = 0;
    chk({tag, "_busy1"}, busy, (ec != 1));
    while (n <= 40) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (rst_at == n) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_zero({tag, "_rst"});
        last_hi = '0; last_lo = '0; last_dbz = 1'b0;
        return;
      end
      if (inj == n) begin
        start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd4;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_cycles"}, n, ec);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
      chk({tag, "_dbz"}, div_by_zero, ed);
      chk({tag, "_busy_at_done"}, busy, 0);
    end
    last_hi = eh; last_lo = el; last_dbz = ed;
  endtask

  task automatic idle_step(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_held"}, {hi, lo, div_by_zero}, {last_hi, last_lo, last_dbz});
    chk({tag, "_idle_alu"}, {alu_in1, alu_in2, alu_cnt}, 0);
  endtask

  initial begin
    logic        ro;
    logic [15:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul300x500", 1'b0, 16'd300, 16'd500, 0, 0);
    idle_step("mul300x500");
    run_op("mulFFFF", 1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
    idle_step("mulFFFF");
    run_op("div1000_7", 1'b1, 16'd1000, 16'd7, 0, 0);
    run_op("divFFFF_1", 1'b1, 16'hFFFF, 16'd1, 0, 0);
    run_op("div8000_8001", 1'b1, 16'h8000, 16'h8001, 0, 0);
    idle_step("div8000_8001");
    run_op("div_zero", 1'b1, 16'd1234, 16'd0, 0, 0);
    idle_step("div_zero");
    run_op("mul2x3_ignore", 1'b0, 16'd2, 16'd3, 5, 0);
    idle_step("mul2x3_ignore");
    run_op("div_rst", 1'b1, 16'd1000, 16'd7, 0, 9);
    idle_step("after_rst");
    run_op("mul3x4", 1'b0, 16'd3, 16'd4, 0, 0);
    idle_step("mul3x4");

    for (int i = 0; i < 60; i++) begin
      int sel;
      ro  = 1'(($urandom_range(0, 1)));
      sel = $urandom_range(0, 9);
      rx  = (sel == 9) ? 16'hFFFF : 16'($urandom);
      if (sel == 0)      ry = 16'd0;
      else if (sel == 1) ry = 16'($urandom_range(1, 3));
      else if (sel == 2) ry = 16'hFFFF;
      else               ry = 16'($urandom);
      run_op($sformatf("rnd%0d", i), ro, rx, ry, 0, 0);
      if ($urandom_range(0, 1) == 0) idle_step($sformatf("rnd%0d", i));
    end
    idle_step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
